// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one pipelined adder among NUM_REQ requesters
// Each requester has at most one op in flight; sums return to per-requester one-entry buffers.
module adder_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]       req_a,
  input  logic [NUM_REQ*WIDTH-1:0]       req_b,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [NUM_REQ*(WIDTH+1)-1:0]   resp_sum,
  output logic [WIDTH-1:0]               adder_a,
  output logic [WIDTH-1:0]               adder_b,
  input  logic [WIDTH:0]                 adder_sum,
  output logic [NUM_REQ-1:0]             busy
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0] eligible, grant, resp_fire;
  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic [LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];
  logic [WIDTH:0]     sum_q [NUM_REQ];
  logic               cap_vld;
  logic [IDW-1:0]     cap_id;

  assign eligible  = req_valid & ~busy_q;
  assign resp_fire = resp_valid_q & resp_ready;
  assign cap_vld   = tag_vld_q[LATENCY-1];
  assign cap_id    = tag_id_q[LATENCY-1];

  // Walk the circular order backwards so the closest eligible index after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (eligible[(int'(last_grant_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (reset && grant_vld) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    adder_a = '0;
    adder_b = '0;
    if (|grant) begin
      adder_a = req_a[grant_idx*WIDTH +: WIDTH];
      adder_b = req_b[grant_idx*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    busy_d       = busy_q & ~resp_fire;
    resp_valid_d = resp_valid_q & ~resp_fire;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      busy_d[grant_idx] = 1'b1;
      last_grant_d      = grant_idx;
    end
    if (cap_vld) resp_valid_d[cap_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      busy_q       <= '0;
      resp_valid_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Tag pipe mirrors the adder latency; no stall, a bubble is just valid=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) sum_q[i] <= '0;
    end else if (cap_vld) begin
      sum_q[cap_id] <= adder_sum;
    end
  end

  always_comb begin
    resp_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) resp_sum[i*(WIDTH+1) +: WIDTH+1] = sum_q[i];
  end

  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered 32-bit carry-lookahead adder pipeline between NUM_REQ independent requesters.
- Arbitrates round-robin, issues at most one add per cycle into the adder and tracks each in-flight op with a tag shift register.
- Steers each returned sum into a per-requester one-entry result buffer.
- Sits between the requesting datapath blocks and the shared adder instance. The adder keeps its own input and output registers; this block only sequences it.

Parameters:
- WIDTH, 32: operand width; sums are WIDTH+1 bits.
- NUM_REQ, 4: number of requesters, 2..8.
- LATENCY, 2: clock edges from adder_a/adder_b being driven to the matching adder_sum being valid.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request i has operands pending.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i is requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- resp_valid  out  NUM_REQ  result buffer i is full.
- resp_ready  in  NUM_REQ  requester i consumes its result.
- resp_sum  out  NUM_REQ*(WIDTH+1)  packed result buffers.
- adder_a  out  WIDTH  operand A to the shared adder.
- adder_b  out  WIDTH  operand B to the shared adder.
- adder_sum  in  WIDTH+1  sum from the shared adder, LATENCY edges after issue.
- busy  out  NUM_REQ  requester i has an op in flight or an unconsumed result.

Behaviour:
- Reset (reset low, asynchronous):
  - busy, resp_valid and every tag-pipe valid bit clear; resp_sum is all zeros.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - req_ready and adder_a/adder_b are 0 while reset is asserted.
- Eligibility: eligible[i] = req_valid[i] and not busy[i]. Each requester has at most one op outstanding.
- Grant (combinational, one-hot or zero):
  - Select the first eligible index, searching circularly from last_grant+1.
  - req_ready = grant; req_ready may depend combinationally on req_valid.
  - Requesters hold req_valid and operands stable until accepted.
- adder_a/adder_b: carry the granted slice of req_a/req_b in the grant cycle; otherwise 0.
- On a grant edge:
  - last_grant takes the granted index; it is unchanged when nothing is granted.
  - busy[i] is set.
  - Tag pipe stage 0 loads {valid=1, id=i}; with no grant it loads valid=0.
- Tag pipe: LATENCY stages, shifts every cycle, no stall. When the last stage is valid:
  - adder_sum is captured into resp_sum slice id on the same edge the sum is valid;
  - resp_valid[id] is set.
- Result buffers:
  - Buffer i never overflows, because busy[i] blocks a second issue.
  - resp_valid[i] clears on the edge where resp_valid[i] and resp_ready[i] are both high.
  - busy[i] clears on that same edge.
  - resp_sum is held after consumption; it is not cleared.
- Timing and throughput:
  - Issue at edge t makes the result visible on resp_valid after edge t+LATENCY, i.e. LATENCY+1 cycles from grant to resp_valid.
  - A requester becomes eligible again the cycle after its response handshake. It is not eligible in the handshake cycle itself.
  - Minimum per-requester period is LATENCY+2 cycles; aggregate throughput is one issue per cycle.
- Arithmetic: unsigned. The carry out is bit WIDTH of resp_sum; no truncation.
- Simultaneous events: grant to j and capture for k≠j on the same edge are independent. Grant to i and capture for i cannot coincide.
- Reset mid-operation:
  - In-flight tags and buffered results are discarded.
  - Sums arriving from the adder after reset release are ignored, because tag valids are 0.
  - The adder's own registers are not reset by this block.

Test Plan:
- Reset, then requester 0 alone with a=0x0000_0005, b=0x0000_0003 → req_ready[0] high in the same cycle; resp_valid[0] high 3 cycles later with resp_sum[0]=33'h0_0000_0008; busy[0] high until the response handshake.
- Overflow: a=b=0xFFFF_FFFF on requester 2 → resp_sum slice 2 = 33'h1_FFFF_FFFE.
- All 4 requesters valid continuously, resp_ready=all 1s → grants in order 0,1,2,3 on consecutive cycles; results return in order 0,1,2,3; next grant to 0 occurs only after its handshake plus 1 cycle.
- Requester 1 result held with resp_ready[1]=0 for 10 cycles while 1 keeps req_valid → req_ready[1] stays 0 and resp_sum[1] is stable; other requesters are still served round-robin.
- Pointer fairness: requesters 1 and 3 valid, last_grant=1 → grant 3 first, then 1; none starve over 20 cycles.
- Assert reset low with two ops in flight → resp_valid and busy are 0 immediately (asynchronous); after release, no stale resp_valid appears within LATENCY+1 cycles.
